// File: rtl/cpu_div_pkg.sv
// rtl/cpu_div_pkg.sv - shared types and helpers for the multicycle divider
package cpu_div_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};
  // Borrow out of the extra bit means the trial went negative: restore.
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle restoring divider for DIV/DIVU, quotient to lo, remainder to hi
module div_unit
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [CNT_W-1:0] counter
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .dvs_i (b_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          sgn_d   = is_signed;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (b_q == '0) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          // 0x80000000 negates to itself, which is already the correct unsigned magnitude.
          quo_d   = (sgn_q && a_q[WIDTH-1]) ? neg32(a_q) : a_q;
          b_d     = (sgn_q && b_q[WIDTH-1]) ? neg32(b_q) : b_q;
          qneg_d  = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rneg_d  = sgn_q && a_q[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = qneg_q ? neg32(quo_q) : quo_q;
        hi_d    = rneg_q ? neg32(rem_q) : rem_q;
        state_d = DONE;
      end
      DONE: begin
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign counter  = cnt_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [4:0]  counter;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo),
    .counter   (counter)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one start, optionally re-pulses start with other operands at cycle pulse_at,
  // and returns the cycle count to done plus the values seen in the done cycle.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output int lat, output logic dz,
                        output logic [31:0] h, output logic [31:0] l, output logic busy_ok);
    logic seen;
    seen    = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    dz      = 1'b0;
    h       = '0;
    l       = '0;
    @(negedge clock);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1 start = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (!busy) busy_ok = 1'b0;
      if (lat == pulse_at) begin
        start     = 1'b1;
        is_signed = ~s;
        dividend  = ~a;
        divisor   = b + 32'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        dz   = div_zero;
        h    = hi;
        l    = lo;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  logic        dz, bok;
  logic [31:0] h, l;

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_cnt", {27'd0, counter}, 32'd0);
    reset = 1'b1;

    run_op(1'b1, 32'd100, 32'd7, 0, lat, dz, h, l, bok);
    check("s100_7_lat", lat, 32'd34);
    check("s100_7_lo", l, 32'd14);
    check("s100_7_hi", h, 32'd2);
    check("s100_7_dz", {31'd0, dz}, 32'd0);
    check("s100_7_busy", {31'd0, bok}, 32'd1);
    @(negedge clock);
    check("s100_7_done_pulse", {31'd0, done}, 32'd0);
    check("s100_7_idle", {31'd0, busy}, 32'd0);
    check("s100_7_cnt_wrap", {27'd0, counter}, 32'd0);

    run_op(1'b1, 32'd5, 32'd0, 0, lat, dz, h, l, bok);
    check("dz_lat", lat, 32'd1);
    check("dz_flag", {31'd0, dz}, 32'd1);
    check("dz_hi_kept", h, 32'd2);
    check("dz_lo_kept", l, 32'd14);
    @(negedge clock);
    check("dz_clear", {31'd0, div_zero}, 32'd0);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, dz, h, l, bok);
    check("sneg7_2_lo", l, 32'hFFFF_FFFD);
    check("sneg7_2_hi", h, 32'hFFFF_FFFF);

    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 0, lat, dz, h, l, bok);
    check("u_max_2_lo", l, 32'h7FFF_FFFF);
    check("u_max_2_hi", h, 32'd1);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, dz, h, l, bok);
    check("s_ovf_lo", l, 32'h8000_0000);
    check("s_ovf_hi", h, 32'd0);
    check("s_ovf_dz", {31'd0, dz}, 32'd0);

    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, dz, h, l, bok);
    check("u_big_lo", l, 32'd0);
    check("u_big_hi", h, 32'h8000_0000);

    run_op(1'b0, 32'd1000, 32'd9, 10, lat, dz, h, l, bok);
    check("ign_lat", lat, 32'd34);
    check("ign_lo", l, 32'd111);
    check("ign_hi", h, 32'd1);

    @(negedge clock);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd12345;
    divisor   = 32'd10;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (15) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    check("mid_rst_cnt", {27'd0, counter}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    run_op(1'b1, 32'd9, 32'd3, 0, lat, dz, h, l, bok);
    check("post_rst_lat", lat, 32'd34);
    check("post_rst_lo", l, 32'd3);
    check("post_rst_hi", h, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
